// File: rtl/frase_pkg.sv
// Shared types and constants for the phrase-RAM line reader.
package frase_pkg;

    localparam int unsigned DEPTH     = 65;
    localparam int unsigned CNT_W     = 7;
    localparam logic [7:0]  FILL_CHAR = 8'h20;

    typedef logic [7:0] char_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/frase_reader_if.sv
// Request, RAM read port and renderer port of the phrase reader, bundled as one bus.
interface frase_reader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 7
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  len;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  char_idx;
    logic [DATA_W-1:0] char_out;

    modport master (
        output start, base_addr, len, ram_q, char_idx,
        input  ram_addr, busy, done, count, char_out
    );

    modport slave (
        input  start, base_addr, len, ram_q, char_idx,
        output ram_addr, busy, done, count, char_out
    );
endinterface

// File: rtl/frase_line_buf.sv
// Character line buffer: append-only write port with valid count and a
// registered, fill-padded read port for the renderer.
module frase_line_buf #(
    parameter int unsigned       DEPTH     = 65,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CNT_W     = 7,
    parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [CNT_W-1:0]  rd_idx_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= FILL_CHAR;
            end
            count_q <= '0;
            rdata_q <= FILL_CHAR;
        end else begin
            // Clearing the count invalidates every entry without touching the array.
            if (clear_i) begin
                count_q <= '0;
            end else if (we_i && (count_q < CNT_W'(DEPTH))) begin
                mem_q[count_q] <= wdata_i;
                count_q        <= count_q + CNT_W'(1);
            end
            rdata_q <= (rd_idx_i < count_q) ? mem_q[rd_idx_i] : FILL_CHAR;
        end
    end

    assign count_o = count_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/frase_reader.sv
// Phrase RAM reader: streams a window of RAM bytes into a line buffer on request.
// Build option FRASE_NUL_STOP_EN: a captured 8'h00 terminates the fetch early.
module frase_reader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       READ_LAT  = 1,
    parameter int unsigned       DEPTH     = frase_pkg::DEPTH,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(frase_pkg::FILL_CHAR)
) (
    input  logic          clock,
    input  logic          reset_n,
    frase_reader_if.slave bus
);
    import frase_pkg::*;

    localparam int unsigned       PIPE_W    = (READ_LAT == 0) ? 1 : READ_LAT;
    // Pipeline stages that still hold a read after the oldest one is captured.
    localparam logic [PIPE_W-1:0] KEEP_MASK =
        (READ_LAT > 1) ? PIPE_W'((1 << (READ_LAT - 1)) - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIPE_W-1:0] pipe_q, pipe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  len_clamp;
    logic              accept, issue_v, issue_last, cap_v, in_flight, nul_hit, buf_we;

    always_comb begin
        len_clamp  = (bus.len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.len;
        accept     = (state_q == IDLE) && bus.start;
        issue_v    = (state_q == FETCH);
        issue_last = issue_v && (issue_q == len_q - CNT_W'(1));
        cap_v      = (READ_LAT == 0) ? issue_v : pipe_q[PIPE_W-1];
        in_flight  = |(pipe_q & KEEP_MASK);
    end

`ifdef FRASE_NUL_STOP_EN
    assign nul_hit = cap_v && (bus.ram_q == '0);
`else
    assign nul_hit = 1'b0;
`endif

    assign buf_we = cap_v && !nul_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (len_clamp == '0) ? DONE : FETCH;
            FETCH:   if (issue_last) state_d = (READ_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (!in_flight) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (nul_hit) state_d = DONE;
    end

    always_comb begin
        len_d   = len_q;
        issue_d = issue_q;
        addr_d  = addr_q;
        pipe_d  = PIPE_W'({pipe_q, issue_v});
        busy_d  = (state_d == FETCH) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
        if (accept) begin
            len_d   = len_clamp;
            issue_d = '0;
            if (len_clamp != '0) addr_d = bus.base_addr;
        end else if (issue_v && !issue_last && !nul_hit) begin
            issue_d = issue_q + CNT_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
        end
        // Early termination drops every read still in flight.
        if (nul_hit) pipe_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= '0;
            issue_q <= '0;
            addr_q  <= '0;
            pipe_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            len_q   <= len_d;
            issue_q <= issue_d;
            addr_q  <= addr_d;
            pipe_q  <= pipe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    frase_line_buf #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .FILL_CHAR (FILL_CHAR)
    ) u_line_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (accept),
        .we_i     (buf_we),
        .wdata_i  (bus.ram_q),
        .rd_idx_i (bus.char_idx),
        .count_o  (bus.count),
        .rdata_o  (bus.char_out)
    );

endmodule

// File: tb/tb_frase_reader.sv
// Bench for frase_reader: RAM model with one-cycle latency plus a window-copy reference.
module tb_frase_reader;

    localparam int RL    = 1;
    localparam int LIMIT = 200;
`ifdef FRASE_NUL_STOP_EN
    localparam bit NUL_EN = 1'b1;
`else
    localparam bit NUL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frase_reader_if bus ();

    frase_reader #(.READ_LAT(RL)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    logic [7:0] ram [256];
    always @(posedge clk) bus.ram_q <= ram[bus.ram_addr];

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_buf [65];
    logic [7:0] addr_log [$];
    logic       busy_log [$];
    int         done_cyc;
    int         ndone;

    // Reference: copy the clamped window, stopping at a NUL when that option is built in.
    function automatic void model_fetch(input logic [7:0] base, input logic [6:0] len,
                                        output int n, output int dcyc);
        int lim;
        int stop_at;
        logic [7:0] b;
        lim     = (int'(len) > 65) ? 65 : int'(len);
        stop_at = -1;
        n       = 0;
        for (int i = 0; i < lim; i++) begin
            b = ram[8'(int'(base) + i)];
            if (NUL_EN && b == 8'h00) begin
                stop_at = i;
                break;
            end
            exp_buf[n] = b;
            n++;
        end
        if (len == 7'd0)       dcyc = 1;
        else if (stop_at >= 0) dcyc = stop_at + 1 + RL + 1;
        else                   dcyc = lim + RL + 1;
    endfunction

    task automatic fill_ram(input bit allow_zero);
        for (int a = 0; a < 256; a++) begin
            if (allow_zero && $urandom_range(0, 15) == 0) ram[a] = 8'h00;
            else ram[a] = 8'($urandom_range(1, 255));
        end
    endtask

    // Pulse start, then log ram_addr/busy/done per cycle until shortly after done.
    task automatic do_fetch(input logic [7:0] base, input logic [6:0] len, input int restart_at);
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = base; bus.len = len;
        @(negedge clk);
        bus.start = 1'b0;
        addr_log.delete(); busy_log.delete();
        done_cyc = -1; ndone = 0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            addr_log.push_back(bus.ram_addr);
            busy_log.push_back(bus.busy);
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            bus.start = (cyc == restart_at);
            if (cyc == restart_at) begin bus.base_addr = ~base; bus.len = 7'd9; end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic read_char(input logic [6:0] idx, output logic [7:0] val);
        bus.char_idx = idx;
        @(negedge clk);
        val = bus.char_out;
    endtask

    task automatic test_reset();
        logic [7:0] c;
        fill_ram(1'b0);
        rst_n = 1'b0; bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.char_idx = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.ram_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.ram_addr); end
        checks++; if (bus.char_out !== 8'h20) begin errors++; $display("FAIL reset_char: got %h want 20", bus.char_out); end
        rst_n = 1'b1;
        read_char(7'd64, c);
        checks++; if (c !== 8'h20) begin errors++; $display("FAIL reset_char64: got %h want 20", c); end
    endtask

    task automatic test_basic();
        logic [7:0] c;
        int bad;
        for (int k = 0; k < 256; k++) ram[k] = 8'(8'h41 + k);
        do_fetch(8'h00, 7'd5, 0);
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL basic_latency: got %0d want 7", done_cyc); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL basic_ndone: got %0d want 1", ndone); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (addr_log[i] !== 8'(i)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_log[i], 8'(i)); end
        end
        bad = 0;
        for (int i = 0; i < done_cyc && i < busy_log.size(); i++)
            if (busy_log[i] !== ((i + 1) < done_cyc)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles want 0", bad); end
        checks++; if (bus.count !== 7'd5) begin errors++; $display("FAIL basic_count: got %0d want 5", bus.count); end
        for (int i = 0; i < 6; i++) begin
            read_char(7'(i), c);
            checks++;
            if (c !== ((i < 5) ? 8'(8'h41 + i) : 8'h20)) begin
                errors++; $display("FAIL basic_char%0d: got %h want %h", i, c, (i < 5) ? 8'(8'h41 + i) : 8'h20);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] c;
        logic [7:0] exp_a [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        fill_ram(1'b0);
        do_fetch(8'hFE, 7'd3, 0);
        checks++; if (done_cyc != 3 + RL + 1) begin errors++; $display("FAIL wrap_latency: got %0d want %0d", done_cyc, 3 + RL + 1); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_log[i], exp_a[i]); end
            read_char(7'(i), c);
            checks++;
            if (c !== ram[exp_a[i]]) begin errors++; $display("FAIL wrap_char%0d: got %h want %h", i, c, ram[exp_a[i]]); end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] c;
        logic [7:0] base;
        fill_ram(1'b0);
        base = 8'($urandom);
        do_fetch(base, 7'd100, 0);
        checks++; if (done_cyc != 65 + RL + 1) begin errors++; $display("FAIL clamp_latency: got %0d want %0d", done_cyc, 65 + RL + 1); end
        checks++; if (bus.count !== 7'd65) begin errors++; $display("FAIL clamp_count: got %0d want 65", bus.count); end
        read_char(7'd64, c);
        checks++; if (c !== ram[8'(base + 8'd64)]) begin errors++; $display("FAIL clamp_char64: got %h want %h", c, ram[8'(base + 8'd64)]); end
        read_char(7'd65, c);
        checks++; if (c !== 8'h20) begin errors++; $display("FAIL clamp_char65: got %h want 20", c); end
        read_char(7'd127, c);
        checks++; if (c !== 8'h20) begin errors++; $display("FAIL clamp_char127: got %h want 20", c); end
    endtask

    task automatic test_restart_ignored();
        logic [7:0] c;
        fill_ram(1'b0);
        do_fetch(8'h30, 7'd10, 2);
        checks++; if (ndone != 1) begin errors++; $display("FAIL restart_ndone: got %0d want 1", ndone); end
        checks++; if (done_cyc != 10 + RL + 1) begin errors++; $display("FAIL restart_latency: got %0d want %0d", done_cyc, 10 + RL + 1); end
        checks++; if (bus.count !== 7'd10) begin errors++; $display("FAIL restart_count: got %0d want 10", bus.count); end
        checks++; if (addr_log[addr_log.size() - 1] !== 8'h39) begin errors++; $display("FAIL restart_addr_hold: got %h want 39", addr_log[addr_log.size() - 1]); end
        read_char(7'd9, c);
        checks++; if (c !== ram[8'h39]) begin errors++; $display("FAIL restart_char9: got %h want %h", c, ram[8'h39]); end
        // start raised in the DONE cycle must not launch a new fetch
        do_fetch(8'h50, 7'd3, 3 + RL + 1);
        checks++; if (busy_log[5] !== 1'b0) begin errors++; $display("FAIL done_start_busy: got %b want 0", busy_log[5]); end
        checks++; if (bus.count !== 7'd3) begin errors++; $display("FAIL done_start_count: got %0d want 3", bus.count); end
    endtask

    task automatic test_len_zero();
        logic [7:0] c;
        do_fetch(8'h12, 7'd0, 0);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL len0_latency: got %0d want 1", done_cyc); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL len0_ndone: got %0d want 1", ndone); end
        checks++; if (bus.count !== 7'd0) begin errors++; $display("FAIL len0_count: got %0d want 0", bus.count); end
        checks++; if (busy_log[0] !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy_log[0]); end
        read_char(7'd0, c);
        checks++; if (c !== 8'h20) begin errors++; $display("FAIL len0_char0: got %h want 20", c); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] c;
        int nd, nb;
        fill_ram(1'b0);
        bus.char_idx = 7'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 8'h80; bus.len = 7'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.count !== 7'd1) begin errors++; $display("FAIL midrst_precount: got %0d want 1", bus.count); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.count !== 7'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        checks++; if (bus.char_out !== 8'h20) begin errors++; $display("FAIL midrst_char: got %h want 20", bus.char_out); end
        checks++; if (bus.ram_addr !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h want 00", bus.ram_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0; nb = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
            if (bus.busy === 1'b1) nb++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL midrst_nodone: got %0d pulses want 0", nd); end
        checks++; if (nb != 0) begin errors++; $display("FAIL midrst_nobusy: got %0d cycles want 0", nb); end
        do_fetch(8'h80, 7'd10, 0);
        checks++; if (done_cyc != 10 + RL + 1) begin errors++; $display("FAIL midrst_relatency: got %0d want %0d", done_cyc, 10 + RL + 1); end
        checks++; if (bus.count !== 7'd10) begin errors++; $display("FAIL midrst_recount: got %0d want 10", bus.count); end
        read_char(7'd3, c);
        checks++; if (c !== ram[8'h83]) begin errors++; $display("FAIL midrst_rechar3: got %h want %h", c, ram[8'h83]); end
    endtask

    task automatic test_nul();
        logic [7:0] c;
        logic [7:0] msg [8];
        int n, d;
        msg[0] = 8'h48; msg[1] = 8'h4F; msg[2] = 8'h4C; msg[3] = 8'h41;
        msg[4] = 8'h00; msg[5] = 8'h58; msg[6] = 8'h59; msg[7] = 8'h5A;
        fill_ram(1'b0);
        for (int i = 0; i < 8; i++) ram[8'h10 + i] = msg[i];
        model_fetch(8'h10, 7'd8, n, d);
        do_fetch(8'h10, 7'd8, 0);
        checks++; if (ndone != 1) begin errors++; $display("FAIL nul_ndone: got %0d want 1", ndone); end
        checks++; if (done_cyc != d) begin errors++; $display("FAIL nul_latency: got %0d want %0d", done_cyc, d); end
        checks++; if (bus.count !== (NUL_EN ? 7'd4 : 7'd8)) begin errors++; $display("FAIL nul_count: got %0d want %0d", bus.count, NUL_EN ? 4 : 8); end
        read_char(7'd3, c);
        checks++; if (c !== 8'h41) begin errors++; $display("FAIL nul_char3: got %h want 41", c); end
        read_char(7'd4, c);
        checks++; if (c !== (NUL_EN ? 8'h20 : 8'h00)) begin errors++; $display("FAIL nul_char4: got %h want %h", c, NUL_EN ? 8'h20 : 8'h00); end
    endtask

    task automatic test_random();
        logic [7:0] c, base, e;
        logic [6:0] len;
        int n, d, ra;
        for (int it = 0; it < 25; it++) begin
            fill_ram(1'b1);
            base = 8'($urandom);
            len  = 7'($urandom_range(0, 100));
            ra   = (len >= 7'd4) ? $urandom_range(0, 3) : 0;
            model_fetch(base, len, n, d);
            do_fetch(base, len, ra);
            checks++; if (done_cyc != d) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, done_cyc, d); end
            checks++; if (ndone != 1) begin errors++; $display("FAIL rnd%0d_ndone: got %0d want 1", it, ndone); end
            checks++; if (int'(bus.count) != n) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", it, bus.count, n); end
            for (int i = 0; i < n && i < addr_log.size(); i++) begin
                checks++;
                if (addr_log[i] !== 8'(int'(base) + i)) begin errors++; $display("FAIL rnd%0d_addr%0d: got %h want %h", it, i, addr_log[i], 8'(int'(base) + i)); end
            end
            for (int i = 0; i <= 67; i++) begin
                int idx;
                idx = (i == 67) ? 127 : i;
                e = (idx < n) ? exp_buf[idx] : 8'h20;
                read_char(7'(idx), c);
                checks++;
                if (c !== e) begin errors++; $display("FAIL rnd%0d_char%0d: got %h want %h", it, idx, c, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_restart_ignored();
        test_len_zero();
        test_reset_mid_fetch();
        test_nul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
